// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU function codes, arbiter state encoding and datapath widths.
package alu_pkg;
  localparam int WIDTH = 16;
  localparam int FW = 3;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR = 3'b011;
  localparam logic [2:0] ALU_SHL = 3'b100;
  localparam logic [2:0] ALU_SHR = 3'b101;
  localparam logic [2:0] ALU_LDH = 3'b110;
  localparam logic [2:0] ALU_ILL = 3'b111;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  function automatic logic is_ill(input logic [FW-1:0] f);
    return f == ALU_ILL;
  endfunction
endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: two request channels, the tagged response channel and the ALU port.
interface alu_arbiter_if #(parameter int WIDTH = alu_pkg::WIDTH, parameter int FW = alu_pkg::FW);
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [WIDTH-1:0] req0_x, req0_y, req1_x, req1_y;
  logic [FW-1:0] req0_f, req1_f;
  logic rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [WIDTH-1:0] rsp_data, alu_x, alu_y, alu_out;
  logic [FW-1:0] alu_f;
  modport master (
    output req0_valid, req0_x, req0_y, req0_f, req1_valid, req1_x, req1_y, req1_f, rsp_ready, alu_out,
    input req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data, rsp_err, alu_x, alu_y, alu_f
  );
  modport slave (
    input req0_valid, req0_x, req0_y, req0_f, req1_valid, req1_x, req1_y, req1_f, rsp_ready, alu_out,
    output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data, rsp_err, alu_x, alu_y, alu_f
  );
endinterface

// File: rtl/alu_arbiter_rr_arb2.sv
// rr_arb2: two-input round-robin grant; on contention the requester not served last wins.
module rr_arb2 (
  input  logic v0_i,
  input  logic v1_i,
  input  logic last_i,
  output logic gnt_o,
  output logic any_o
);
  assign gnt_o = (v0_i && v1_i) ? !last_i : v1_i;
  assign any_o = v0_i || v1_i;
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters, one op in flight.
// ALU_ARB_ILLEGAL_EN: reject f==ALU_ILL with rsp_err after one cycle instead of executing it.
module alu_arbiter #(
  parameter int WIDTH = alu_pkg::WIDTH,
  parameter int FW = alu_pkg::FW
) (
  input logic clk,
  input logic rst_n,
  alu_arbiter_if.slave bus
);
  import alu_pkg::*;
  logic [1:0] state_q, state_d;
  logic last_q, last_d, rid_q, rid_d, err_q, err_d;
  logic [WIDTH-1:0] x_q, x_d, y_q, y_d, data_q, data_d;
  logic [FW-1:0] f_q, f_d, f_sel;
  logic gnt, any, acc, ill;
  rr_arb2 u_arb (.v0_i(bus.req0_valid), .v1_i(bus.req1_valid), .last_i(last_q), .gnt_o(gnt), .any_o(any));
  assign f_sel = gnt ? bus.req1_f : bus.req0_f;
`ifdef ALU_ARB_ILLEGAL_EN
  assign ill = is_ill(f_sel);
`else
  assign ill = 1'b0;
`endif
  // ready is gated by rst_n so nothing is acknowledged while reset is held
  assign acc = rst_n && state_q == IDLE && any;
  always_comb begin
    x_d = acc ? (gnt ? bus.req1_x : bus.req0_x) : x_q;
    y_d = acc ? (gnt ? bus.req1_y : bus.req0_y) : y_q;
    f_d = acc ? f_sel : f_q;
    last_d = acc ? gnt : last_q;
    rid_d = state_q == EXEC ? last_q : (acc && ill) ? gnt : rid_q;
    data_d = state_q == EXEC ? bus.alu_out : (acc && ill) ? '0 : data_q;
    err_d = state_q == EXEC ? 1'b0 : (acc && ill) ? 1'b1 : err_q;
    state_d = state_q == IDLE ? (acc ? (ill ? RESP : EXEC) : IDLE) :
              state_q == EXEC ? RESP : (bus.rsp_ready ? IDLE : RESP);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q <= 1'b1;
      rid_q <= 1'b0;
      err_q <= 1'b0;
      x_q <= '0;
      y_q <= '0;
      f_q <= '0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      rid_q <= rid_d;
      err_q <= err_d;
      x_q <= x_d;
      y_q <= y_d;
      f_q <= f_d;
      data_q <= data_d;
    end
  end
  assign bus.req0_ready = acc && !gnt;
  assign bus.req1_ready = acc && gnt;
  assign bus.rsp_valid = state_q == RESP;
  assign bus.rsp_id = rid_q;
  assign bus.rsp_data = data_q;
  assign bus.rsp_err = err_q;
  assign bus.alu_x = x_q;
  assign bus.alu_y = y_q;
  assign bus.alu_f = f_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed checks of arbitration, latency, backpressure and reset for alu_arbiter.
module tb_alu_arbiter;
  import alu_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  int ng = 0;
  int nr = 0;
  always #5 clk = ~clk;
  alu_arbiter_if bus ();
  alu_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  function automatic logic [15:0] alu(input logic [15:0] x, input logic [15:0] y, input logic [2:0] f);
    logic [4:0] sh;
    sh = {1'b0, y[3:0]} + 5'd1;
    case (f)
      ALU_SUB: return x - y;
      ALU_AND: return x & y;
      ALU_OR:  return x | y;
      ALU_SHL: return x << sh;
      ALU_SHR: return x >> sh;
      ALU_LDH: return {y[7:0], x[7:0]};
      default: return x + y;
    endcase
  endfunction
  assign bus.alu_out = alu(bus.alu_x, bus.alu_y, bus.alu_f);
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic req(input int n, input logic v, input logic [15:0] x, input logic [15:0] y, input logic [2:0] f);
    if (n == 0) begin
      bus.req0_valid = v; bus.req0_x = x; bus.req0_y = y; bus.req0_f = f;
    end else begin
      bus.req1_valid = v; bus.req1_x = x; bus.req1_y = y; bus.req1_f = f;
    end
  endtask
  initial begin
    req(0, 0, 0, 0, 0);
    req(1, 1, 16'h0009, 16'h0009, ALU_ADD);
    bus.rsp_ready = 0;
    @(negedge clk); @(negedge clk); #1;
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_req1_ready", bus.req1_ready, 0);
    chk("rst_alu_x", bus.alu_x, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_rsp_err", bus.rsp_err, 0);
    bus.req1_valid = 0;
    @(negedge clk); rst_n = 1;
    @(negedge clk);
    req(0, 1, 16'h0003, 16'h0004, ALU_ADD); #1;
    chk("add_ready0", bus.req0_ready, 1);
    @(negedge clk); bus.req0_valid = 0; #1;
    chk("add_exec_valid", bus.rsp_valid, 0);
    chk("add_alu_x", bus.alu_x, 16'h0003);
    chk("add_alu_y", bus.alu_y, 16'h0004);
    @(negedge clk); #1;
    chk("add_valid", bus.rsp_valid, 1);
    chk("add_id", bus.rsp_id, 0);
    chk("add_data", bus.rsp_data, 16'h0007);
    bus.rsp_ready = 1;
    @(negedge clk); #1;
    chk("add_done", bus.rsp_valid, 0);
    req(1, 1, 16'h0001, 16'h0003, ALU_SHL); #1;
    chk("shl_ready1", bus.req1_ready, 1);
    @(negedge clk); bus.req1_valid = 0;
    @(negedge clk); #1;
    chk("shl_valid", bus.rsp_valid, 1);
    chk("shl_id", bus.rsp_id, 1);
    chk("shl_data", bus.rsp_data, 16'h0010);
    @(negedge clk);
    rst_n = 0;
    @(negedge clk); rst_n = 1;
    req(0, 1, 16'h0010, 16'h0001, ALU_ADD);
    req(1, 1, 16'h0020, 16'h0005, ALU_SUB);
    for (int i = 0; i < 20 && (ng < 4 || nr < 4); i++) begin
      #1;
      chk("rr_one_ready", bus.req0_ready && bus.req1_ready, 0);
      if (bus.req0_ready || bus.req1_ready) begin
        chk("rr_grant", bus.req1_ready, ng % 2);
        ng++;
      end
      if (bus.rsp_valid) begin
        chk("rr_id", bus.rsp_id, nr % 2);
        chk("rr_data", bus.rsp_data, (nr % 2) ? 16'h001B : 16'h0011);
        nr++;
      end
      @(negedge clk);
    end
    bus.req0_valid = 0; bus.req1_valid = 0;
    chk("rr_grants", ng, 4);
    chk("rr_resps", nr, 4);
    bus.rsp_ready = 0;
    req(0, 1, 16'h00FF, 16'h0F0F, ALU_AND);
    req(1, 1, 16'h00F0, 16'h000F, ALU_OR); #1;
    chk("bp_ready0", bus.req0_ready, 1);
    chk("bp_ready1", bus.req1_ready, 0);
    @(negedge clk); bus.req0_valid = 0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_valid", bus.rsp_valid, 1);
      chk("bp_id", bus.rsp_id, 0);
      chk("bp_data", bus.rsp_data, 16'h000F);
      chk("bp_ready1_hold", bus.req1_ready, 0);
      @(negedge clk);
    end
    bus.rsp_ready = 1; #1;
    chk("bp_hs_ready1", bus.req1_ready, 0);
    chk("bp_hs_valid", bus.rsp_valid, 1);
    @(negedge clk); #1;
    chk("bp_after_valid", bus.rsp_valid, 0);
    chk("bp_after_ready1", bus.req1_ready, 1);
    @(negedge clk); bus.req1_valid = 0;
    @(negedge clk); #1;
    chk("bp_r1_valid", bus.rsp_valid, 1);
    chk("bp_r1_id", bus.rsp_id, 1);
    chk("bp_r1_data", bus.rsp_data, 16'h00FF);
    @(negedge clk);
    req(1, 1, 16'h1111, 16'h2222, ALU_ADD);
    @(negedge clk);
    rst_n = 0; #1;
    chk("mid_rst_valid", bus.rsp_valid, 0);
    chk("mid_rst_data", bus.rsp_data, 0);
    chk("mid_rst_id", bus.rsp_id, 0);
    chk("mid_rst_alu_x", bus.alu_x, 0);
    chk("mid_rst_ready1", bus.req1_ready, 0);
    bus.req1_valid = 0; bus.rsp_ready = 0;
    @(negedge clk); rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("mid_rst_stray", bus.rsp_valid, 0);
    end
    req(0, 1, 16'h0100, 16'h0001, ALU_SHR);
    req(1, 1, 16'h0001, 16'h0001, ALU_ADD); #1;
    chk("mid_rst_grant0", bus.req0_ready, 1);
    chk("mid_rst_grant1", bus.req1_ready, 0);
    @(negedge clk); bus.req0_valid = 0; bus.req1_valid = 0;
    @(negedge clk); #1;
    chk("shr_valid", bus.rsp_valid, 1);
    chk("shr_id", bus.rsp_id, 0);
    chk("shr_data", bus.rsp_data, 16'h0040);
    bus.rsp_ready = 1;
    @(negedge clk);
    req(0, 1, 16'h0005, 16'h0005, ALU_ILL);
    @(negedge clk); bus.req0_valid = 0; #1;
    chk("ill_alu_x", bus.alu_x, 16'h0005);
    chk("ill_alu_f", bus.alu_f, ALU_ILL);
`ifdef ALU_ARB_ILLEGAL_EN
    chk("ill_valid", bus.rsp_valid, 1);
    chk("ill_err", bus.rsp_err, 1);
    chk("ill_data", bus.rsp_data, 0);
`else
    chk("ill_exec", bus.rsp_valid, 0);
    @(negedge clk); #1;
    chk("ill_valid", bus.rsp_valid, 1);
    chk("ill_err", bus.rsp_err, 0);
    chk("ill_data", bus.rsp_data, 16'h000A);
`endif
    @(negedge clk); #1;
    chk("ill_done", bus.rsp_valid, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares the single 16-bit combinational ALU between two requesters (e.g. fetch/address unit and execute unit).
- Arbitrates requests round-robin.
- Registers the winning operands and drives the ALU for one cycle.
- Captures the result and returns it through a tagged valid/ready response channel.
- At most one operation is in flight at a time.

Parameters:
WIDTH, 16, operand/result width; must match the ALU datapath.
FW, 3, ALU function-code width.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
req0_valid  in  1  requester 0 has an operation.
req0_ready  out  1  requester 0 operation accepted this cycle.
req0_x  in  WIDTH  requester 0 operand x.
req0_y  in  WIDTH  requester 0 operand y.
req0_f  in  FW  requester 0 function code.
req1_valid/req1_ready/req1_x/req1_y/req1_f  same as requester 0, for requester 1.
rsp_valid  out  1  result available.
rsp_ready  in  1  consumer takes result.
rsp_id  out  1  requester that owns the result.
rsp_data  out  WIDTH  ALU result.
rsp_err  out  1  illegal function code (see Optional Feature).
alu_x  out  WIDTH  to ALU x.
alu_y  out  WIDTH  to ALU y.
alu_f  out  FW  to ALU f.
alu_out  in  WIDTH  from ALU out (combinational).

Behaviour:
- Reset (async, rst_n low): state=IDLE, last_grant=1 (so requester 0 wins first), all ready/valid outputs 0, rsp_id/rsp_data/rsp_err 0, alu_x/alu_y/alu_f 0.
- States:
  - IDLE -> EXEC on acceptance.
  - EXEC -> RESP unconditionally after 1 cycle.
  - RESP -> IDLE when rsp_valid && rsp_ready.
- IDLE grant (combinational):
  - Only req0 valid: grant 0. Only req1 valid: grant 1.
  - Both valid: grant !last_grant.
  - reqN_ready = (state==IDLE) && grant==N && reqN_valid. Never both high.
- Acceptance (reqN_valid && reqN_ready) at edge N:
  - Register x, y, f into alu_x/alu_y/alu_f.
  - Record id; last_grant<=id.
- Operand hold: alu_x/alu_y/alu_f hold their values through EXEC and RESP; they change only on the next acceptance.
- EXEC (cycle N+1): at the edge, rsp_data<=alu_out, rsp_id<=id, rsp_err<=0.
- RESP (from cycle N+2):
  - rsp_valid=1. rsp_id/rsp_data stable until handshake.
  - No new acceptance in RESP; the handshake cycle returns to IDLE.
- Timing: latency accept -> rsp_valid = 2 cycles. Max throughput 1 op / 3 cycles.
- Function codes: passed unchanged to the ALU. The ALU maps 3'b111 to add.
- Request-side rules: requester may drop valid without acceptance (no penalty). Losing requester is not acknowledged and keeps its request pending.
- Reset mid-operation: in-flight operation discarded, no response issued, last_grant back to 1.
- Arithmetic: none inside this block; widths pass through unmodified.

Optional Feature:
Macro ALU_ARB_ILLEGAL_EN.
- Defined:
  - An accepted f==3'b111 skips EXEC: IDLE -> RESP directly.
  - rsp_data=0, rsp_err=1, latency 1 cycle.
  - alu_* still load the operands.
- Undefined:
  - 3'b111 is treated as a normal operation (ALU adds); rsp_err tied 0.
  - Port list identical in both builds.

Decomposition:
- Package alu_pkg holds:
  - function-code localparams: ALU_ADD=000, ALU_SUB=001, ALU_AND=010, ALU_OR=011, ALU_SHL=100, ALU_SHR=101, ALU_LDH=110, ALU_ILL=111;
  - state encoding: IDLE/EXEC/RESP, 2 bits;
  - WIDTH/FW defaults.
- One natural sub-module: rr_arb2 (2-input round-robin grant from valids + last_grant, combinational).

Test Plan:
- Single add: req0 x=0x0003 y=0x0004 f=000 accepted cycle 0 -> rsp_valid cycle 2, rsp_id=0, rsp_data=0x0007.
- Shift via ALU: req1 x=0x0001 y=0x0003 f=100 -> rsp_id=1, rsp_data=0x0010 (shift by y+1).
- Contention: both valid continuously after reset -> grants 0,1,0,1. reqN_ready never both high. Responses carry ids alternating 0,1.
- Backpressure: rsp_ready low 5 cycles in RESP -> rsp_valid, rsp_id, rsp_data held stable, req*_ready stays 0. Accept only in the cycle after the handshake.
- Reset mid-op: assert rst_n low during EXEC -> all outputs 0 immediately. After release, no stray rsp_valid; first grant goes to req0.
- ALU_ARB_ILLEGAL_EN: f=111 x=0x0005 y=0x0005 -> rsp_valid 1 cycle after accept, rsp_err=1, rsp_data=0x0000. Without the macro -> rsp_data=0x000A, rsp_err=0, latency 2.
